ascii_text_renderer: RTL and testbench

- Text-mode pixel generator that sits directly upstream of the ASCII font ROM.
- Holds an 80x30 character screen buffer. For each VGA pixel it fetches the character code, drives the font ROM address {code, glyph row}, and selects one glyph bit from the returned row.
- Emits 12-bit RGB, with the syncs delayed to match.
- On reset, and on request, it clears the whole buffer to spaces.

---
 rtl/text_pkg.sv | 23 ++
 rtl/ascii_text_renderer_if.sv | 28 ++
 rtl/char_buffer.sv | 33 +++
 rtl/ascii_text_renderer.sv | 176 +++++++++++++++++
 tb/tb_ascii_text_renderer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/text_pkg.sv
// ---------------------------------------------------------------------------
// text_pkg : geometry, fill character and shared types for the text renderer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package text_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;
  localparam int CELLS  = COLS * ROWS;

  localparam logic [6:0] CHAR_SPACE = 7'h20;

  typedef enum logic {IDLE, CLEAR} clr_state_t;

  typedef logic [11:0] cell_idx_t;

endpackage

`default_nettype wire

// File: rtl/ascii_text_renderer_if.sv
// ---------------------------------------------------------------------------
// ascii_text_renderer_if : host write/clear bus into the text renderer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ascii_text_renderer_if;

  logic       wr_en_i;
  logic [6:0] wr_col_i;
  logic [4:0] wr_row_i;
  logic [6:0] wr_char_i;
  logic       clear_i;
  logic       busy_o;

  modport master (
    output wr_en_i, wr_col_i, wr_row_i, wr_char_i, clear_i,
    input  busy_o
  );

  modport slave (
    input  wr_en_i, wr_col_i, wr_row_i, wr_char_i, clear_i,
    output busy_o
  );

endinterface

`default_nettype wire

// File: rtl/char_buffer.sv
// ---------------------------------------------------------------------------
// char_buffer : simple dual-port screen RAM, read-first, no reset (block RAM)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module char_buffer #(
  parameter int DEPTH = 2400,
  parameter int DW    = 7,
  parameter int AW    = 12
) (
  input  wire logic          clk_i,
  input  wire logic          we_i,
  input  wire logic [AW-1:0] waddr_i,
  input  wire logic [DW-1:0] wdata_i,
  input  wire logic [AW-1:0] raddr_i,
  output      logic [DW-1:0] rdata_o
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // Same-address collision returns the pre-write contents.
  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[waddr_i] <= wdata_i;
    r_rdata <= r_mem[raddr_i];
  end

  assign rdata_o = r_rdata;

endmodule

`default_nettype wire

// File: rtl/ascii_text_renderer.sv
// ---------------------------------------------------------------------------
// ascii_text_renderer : 80x30 text-mode pixel generator ahead of a font ROM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ascii_text_renderer #(
  parameter logic [11:0] FG_RGB = 12'hFFF,
  parameter logic [11:0] BG_RGB = 12'h000,
  parameter int          COLS   = 80,
  parameter int          ROWS   = 30
) (
  input  wire logic        clk_i,
  input  wire logic        rst_ni,
  input  wire logic [9:0]  x_i,
  input  wire logic [9:0]  y_i,
  input  wire logic        video_on_i,
  input  wire logic        hsync_i,
  input  wire logic        vsync_i,
  ascii_text_renderer_if.slave host,
  output      logic [10:0] rom_addr_o,
  input  wire logic [7:0]  rom_data_i,
  output      logic [11:0] rgb_o,
  output      logic        hsync_o,
  output      logic        vsync_o,
  output      logic        video_on_o
);

  import text_pkg::*;

  localparam cell_idx_t c_last = cell_idx_t'(COLS * ROWS - 1);

  // Stage 1
  logic [9:0] r_x1, r_y1;
  logic       r_von1, r_hs1, r_vs1;
  logic       w_in1;
  cell_idx_t  w_rd_idx;

  // Stage 2
  logic [3:0] r_row2;
  logic [2:0] r_col2;
  logic       r_act2, r_von2, r_hs2, r_vs2;
  logic [6:0] w_char2;

  // Stage 3
  logic [11:0] r_rgb;
  logic        r_hs3, r_vs3, r_von3;
  logic        w_pix;

  // Clear FSM and write port
  clr_state_t r_state;
  cell_idx_t  r_clr_cnt;
  logic       w_wr_ok;
  cell_idx_t  w_wr_idx;
  logic       w_we;
  cell_idx_t  w_waddr;
  logic [6:0] w_wdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_x1   <= '0;
      r_y1   <= '0;
      r_von1 <= 1'b0;
      r_hs1  <= 1'b0;
      r_vs1  <= 1'b0;
    end else begin
      r_x1   <= x_i;
      r_y1   <= y_i;
      r_von1 <= video_on_i;
      r_hs1  <= hsync_i;
      r_vs1  <= vsync_i;
    end
  end

  // Off-screen coordinates read cell 0 and are blanked through r_act2.
  assign w_in1    = (r_x1 < 10'(COLS * CHAR_W)) && (r_y1 < 10'(ROWS * CHAR_H));
  assign w_rd_idx = w_in1 ? (cell_idx_t'(r_y1[8:4]) * cell_idx_t'(COLS)
                             + cell_idx_t'(r_x1[9:3]))
                          : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_row2 <= '0;
      r_col2 <= '0;
      r_act2 <= 1'b0;
      r_von2 <= 1'b0;
      r_hs2  <= 1'b0;
      r_vs2  <= 1'b0;
    end else begin
      r_row2 <= r_y1[3:0];
      r_col2 <= r_x1[2:0];
      r_act2 <= r_von1 && w_in1;
      r_von2 <= r_von1;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
    end
  end

  assign rom_addr_o = {w_char2, r_row2};
  assign w_pix      = rom_data_i[3'd7 - r_col2];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rgb  <= '0;
      r_hs3  <= 1'b0;
      r_vs3  <= 1'b0;
      r_von3 <= 1'b0;
    end else begin
      r_rgb  <= r_act2 ? (w_pix ? FG_RGB : BG_RGB) : 12'h000;
      r_hs3  <= r_hs2;
      r_vs3  <= r_vs2;
      r_von3 <= r_von2;
    end
  end

  assign rgb_o      = r_rgb;
  assign hsync_o    = r_hs3;
  assign vsync_o    = r_vs3;
  assign video_on_o = r_von3;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (host.clear_i) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
          end
        end
        CLEAR: begin
          if (r_clr_cnt == c_last) r_state <= IDLE;
          r_clr_cnt <= r_clr_cnt + cell_idx_t'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign host.busy_o = (r_state == CLEAR);

  assign w_wr_ok  = host.wr_en_i && (host.wr_col_i < 7'(COLS)) && (host.wr_row_i < 5'(ROWS));
  assign w_wr_idx = cell_idx_t'(host.wr_row_i) * cell_idx_t'(COLS) + cell_idx_t'(host.wr_col_i);

  // A clear request wins over a host write issued in the same cycle.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_wr_idx;
    w_wdata = host.wr_char_i;
    if (r_state == CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_clr_cnt;
      w_wdata = CHAR_SPACE;
    end else if (!host.clear_i && w_wr_ok) begin
      w_we = 1'b1;
    end
  end

  char_buffer #(
    .DEPTH (COLS * ROWS),
    .DW    (7),
    .AW    (12)
  ) u_buf (
    .clk_i   (clk_i),
    .we_i    (w_we),
    .waddr_i (w_waddr),
    .wdata_i (w_wdata),
    .raddr_i (w_rd_idx),
    .rdata_o (w_char2)
  );

endmodule

`default_nettype wire

// File: tb/tb_ascii_text_renderer.sv
// ---------------------------------------------------------------------------
// tb_ascii_text_renderer : directed self-checking bench for the text renderer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ascii_text_renderer;

  logic        clk;
  logic        rst_n;
  logic [9:0]  x, y;
  logic        von, hs, vs;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic [11:0] rgb;
  logic        hs_o, vs_o, von_o;
  logic        rom_force;

  int errors = 0;
  int checks = 0;

  ascii_text_renderer_if bus ();

  ascii_text_renderer dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .x_i        (x),
    .y_i        (y),
    .video_on_i (von),
    .hsync_i    (hs),
    .vsync_i    (vs),
    .host       (bus.slave),
    .rom_addr_o (rom_addr),
    .rom_data_i (rom_data),
    .rgb_o      (rgb),
    .hsync_o    (hs_o),
    .vsync_o    (vs_o),
    .video_on_o (von_o)
  );

  // Font ROM model: row byte = low address byte XOR 5A, or all ones when forced.
  assign rom_data = rom_force ? 8'hFF : (rom_addr[7:0] ^ 8'h5A);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_pix(input logic [9:0] px, input logic [9:0] py, input logic pv);
    x = px; y = py; von = pv;
  endtask

  task automatic do_write(input logic [6:0] col, input logic [4:0] row, input logic [6:0] ch);
    bus.wr_en_i = 1'b1; bus.wr_col_i = col; bus.wr_row_i = row; bus.wr_char_i = ch;
    tick();
    bus.wr_en_i = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    hs = 1'b1; vs = 1'b1; von = 1'b1; x = 10'd1; y = 10'd3;
    repeat (3) tick();
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb got=%h exp=000", rgb); end
    checks++; if (hs_o !== 1'b0) begin errors++; $display("FAIL reset_hsync got=%b exp=0", hs_o); end
    checks++; if (vs_o !== 1'b0) begin errors++; $display("FAIL reset_vsync got=%b exp=0", vs_o); end
    checks++; if (von_o !== 1'b0) begin errors++; $display("FAIL reset_video_on got=%b exp=0", von_o); end
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", bus.busy_o); end
    hs = 1'b0; vs = 1'b0;
    rst_n = 1'b1;
    n = 0;
    while (bus.busy_o === 1'b1 && n < 3000) begin tick(); n++; end
    checks++; if (n !== 2400) begin errors++; $display("FAIL init_clear_cycles got=%0d exp=2400", n); end
  endtask

  task automatic test_clear_fill();
    logic [9:0] xs [4] = '{10'd0, 10'd639, 10'd320, 10'd7};
    logic [9:0] ys [4] = '{10'd0, 10'd479, 10'd240, 10'd15};
    for (int i = 0; i < 4; i++) begin
      put_pix(xs[i], ys[i], 1'b1);
      repeat (2) tick();
      checks++;
      if (rom_addr !== {7'h20, ys[i][3:0]}) begin
        errors++; $display("FAIL fill_addr[%0d] got=%h exp=%h", i, rom_addr, {7'h20, ys[i][3:0]});
      end
    end
  endtask

  task automatic test_glyph();
    logic [7:0] row_bits;
    logic [9:0] hs_pat;
    row_bits = 8'h49;          // 8'h13 ^ 8'h5A for address 11'h413
    hs_pat   = 10'b01_1010_0110;
    do_write(7'd0, 5'd0, 7'h41);
    for (int i = 0; i < 10; i++) begin
      x = (i < 8) ? 10'(i) : 10'd100; y = 10'd3; von = 1'b1; hs = hs_pat[i];
      tick();
      if (i >= 1 && i <= 8) begin
        checks++;
        if (rom_addr !== 11'h413) begin
          errors++; $display("FAIL glyph_addr x=%0d got=%h exp=413", i - 1, rom_addr);
        end
      end
      if (i >= 2) begin
        checks++;
        if (rgb !== (row_bits[7 - (i - 2)] ? 12'hFFF : 12'h000)) begin
          errors++; $display("FAIL glyph_rgb x=%0d got=%h exp=%h", i - 2, rgb,
                             row_bits[7 - (i - 2)] ? 12'hFFF : 12'h000);
        end
        checks++;
        if (hs_o !== hs_pat[i - 2]) begin
          errors++; $display("FAIL glyph_hsync i=%0d got=%b exp=%b", i - 2, hs_o, hs_pat[i - 2]);
        end
      end
    end
    hs = 1'b0;
    // 'B' at col 5 row 2, pixel x=42 (bit 5 of 7D) y=39 (glyph row 7)
    do_write(7'd5, 5'd2, 7'h42);
    put_pix(10'd42, 10'd39, 1'b1);
    repeat (2) tick();
    checks++; if (rom_addr !== 11'h427) begin errors++; $display("FAIL glyph_b_addr got=%h exp=427", rom_addr); end
    tick();
    checks++; if (rgb !== 12'hFFF) begin errors++; $display("FAIL glyph_b_rgb got=%h exp=fff", rgb); end
  endtask

  task automatic test_dropped_writes();
    int n;
    do_write(7'd80, 5'd0, 7'h5A);
    do_write(7'd0, 5'd30, 7'h5A);
    put_pix(10'd0, 10'd16, 1'b1);
    repeat (2) tick();
    checks++; if (rom_addr !== 11'h200) begin errors++; $display("FAIL drop_col80 got=%h exp=200", rom_addr); end
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL clear_busy got=%b exp=1", bus.busy_o); end
    n = 0;
    while (bus.busy_o === 1'b1 && n < 3000) begin
      if (n == 2000) begin
        bus.wr_en_i = 1'b1; bus.wr_col_i = 7'd0; bus.wr_row_i = 5'd0; bus.wr_char_i = 7'h5A;
      end else begin
        bus.wr_en_i = 1'b0;
      end
      tick(); n++;
    end
    bus.wr_en_i = 1'b0;
    checks++; if (n !== 2400) begin errors++; $display("FAIL clear_cycles got=%0d exp=2400", n); end
    put_pix(10'd2, 10'd5, 1'b1);
    repeat (2) tick();
    checks++; if (rom_addr !== 11'h205) begin errors++; $display("FAIL drop_busy got=%h exp=205", rom_addr); end
  endtask

  task automatic test_blanking();
    rom_force = 1'b1;
    vs = 1'b1;
    put_pix(10'd1, 10'd3, 1'b0);
    repeat (3) tick();
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL blank_off_rgb got=%h exp=000", rgb); end
    checks++; if (von_o !== 1'b0) begin errors++; $display("FAIL blank_off_von got=%b exp=0", von_o); end
    checks++; if (vs_o !== 1'b1) begin errors++; $display("FAIL blank_vsync got=%b exp=1", vs_o); end
    vs = 1'b0;
    put_pix(10'd700, 10'd3, 1'b1);
    repeat (3) tick();
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL blank_x700_rgb got=%h exp=000", rgb); end
    checks++; if (von_o !== 1'b1) begin errors++; $display("FAIL blank_x700_von got=%b exp=1", von_o); end
    put_pix(10'd5, 10'd5, 1'b1);
    repeat (3) tick();
    checks++; if (rgb !== 12'hFFF) begin errors++; $display("FAIL blank_ctrl_rgb got=%h exp=fff", rgb); end
    put_pix(10'd5, 10'd500, 1'b1);
    repeat (3) tick();
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL blank_y500_rgb got=%h exp=000", rgb); end
    rom_force = 1'b0;
  endtask

  task automatic test_collision();
    put_pix(10'd632, 10'd466, 1'b1);
    tick();
    bus.wr_en_i = 1'b1; bus.wr_col_i = 7'd79; bus.wr_row_i = 5'd29; bus.wr_char_i = 7'h31;
    tick();
    bus.wr_en_i = 1'b0;
    checks++; if (rom_addr !== 11'h202) begin errors++; $display("FAIL collide_old got=%h exp=202", rom_addr); end
    tick();
    checks++; if (rom_addr !== 11'h312) begin errors++; $display("FAIL collide_new got=%h exp=312", rom_addr); end
  endtask

  task automatic test_reset_midclear();
    int n;
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    repeat (1000) tick();
    hs = 1'b1; vs = 1'b1; put_pix(10'd1, 10'd3, 1'b1); rom_force = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    #2;
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL midrst_rgb got=%h exp=000", rgb); end
    checks++; if (hs_o !== 1'b0) begin errors++; $display("FAIL midrst_hsync got=%b exp=0", hs_o); end
    checks++; if (vs_o !== 1'b0) begin errors++; $display("FAIL midrst_vsync got=%b exp=0", vs_o); end
    checks++; if (von_o !== 1'b0) begin errors++; $display("FAIL midrst_von got=%b exp=0", von_o); end
    tick();
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL midrst_busy got=%b exp=1", bus.busy_o); end
    hs = 1'b0; vs = 1'b0; rom_force = 1'b0;
    rst_n = 1'b1;
    n = 0;
    while (bus.busy_o === 1'b1 && n < 3000) begin tick(); n++; end
    checks++; if (n !== 2400) begin errors++; $display("FAIL midrst_clear_cycles got=%0d exp=2400", n); end
  endtask

  initial begin
    rst_n = 1'b0; x = '0; y = '0; von = 1'b0; hs = 1'b0; vs = 1'b0; rom_force = 1'b0;
    bus.wr_en_i = 1'b0; bus.wr_col_i = '0; bus.wr_row_i = '0; bus.wr_char_i = '0; bus.clear_i = 1'b0;
    test_reset();
    test_clear_fill();
    test_glyph();
    test_dropped_writes();
    test_blanking();
    test_collision();
    test_reset_midclear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
